// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, receiver FSM states and the bit-vote helper.
package uart_pkg;

    localparam int unsigned OVERSAMPLE      = 16;
    localparam int unsigned SAMPLE_MID      = 8;
    localparam int unsigned FRAME_DATA_BITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser for an asynchronous single-bit input, with selectable reset value.
module sync_ff #(
    parameter int unsigned STAGES    = 2,
    parameter bit          RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(d);
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detect, mid-bit majority vote, optional even parity,
// one-entry output buffer with valid/ready handshake and overrun pulse.
module uart_rx #(
    parameter int unsigned DATA_BITS   = uart_pkg::FRAME_DATA_BITS,
    parameter int unsigned PARITY_EN   = 1,
    parameter int unsigned OVERSAMPLE  = uart_pkg::OVERSAMPLE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_16x,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);
    import uart_pkg::*;

    localparam int unsigned SCW = $clog2(OVERSAMPLE);
    localparam int unsigned BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SCW-1:0] SC_V0   = SCW'(SAMPLE_MID - 1);
    localparam logic [SCW-1:0] SC_V1   = SCW'(SAMPLE_MID);
    localparam logic [SCW-1:0] SC_V2   = SCW'(SAMPLE_MID + 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_BITS - 1);

    logic rx_s;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_pin),
        .q     (rx_s)
    );

    rx_state_e            state_q, state_d;
    logic [SCW-1:0]       scnt_q, scnt_d;
    logic [BCW-1:0]       bcnt_q, bcnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_q, ferr_d;
    logic                 overrun_q, overrun_d;

    logic vote, at_vote, at_wrap;

    always_comb begin
        state_d    = state_q;
        scnt_d     = scnt_q;
        bcnt_d     = bcnt_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_d     = ferr_q;
        overrun_d  = 1'b0;

        // Third vote sample is the live synchronised value on the scnt=MID+1 tick.
        vote    = maj3(samp_q[1], samp_q[0], rx_s);
        at_vote = tick_16x && (scnt_q == SC_V2);
        at_wrap = tick_16x && (scnt_q == SC_LAST);

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        if (tick_16x && (state_q != StIdle) && (state_q != StBreak)) begin
            scnt_d = (scnt_q == SC_LAST) ? '0 : scnt_q + 1'b1;
            if (scnt_q == SC_V0) samp_d[1] = rx_s;
            if (scnt_q == SC_V1) samp_d[0] = rx_s;
        end

        case (state_q)
            StIdle: begin
                if (tick_16x && !rx_s) begin
                    state_d = StStart;
                    scnt_d  = '0;
                end
            end
            StStart: begin
                if (at_vote && vote) begin
                    state_d = StIdle;
                    scnt_d  = '0;
                end else if (at_wrap) begin
                    state_d = StData;
                    bcnt_d  = '0;
                    perr_d  = 1'b0;
                end
            end
            StData: begin
                if (at_vote) shift_d[bcnt_q] = vote;
                if (at_wrap) begin
                    if (bcnt_q == BC_LAST) begin
                        state_d = (PARITY_EN != 0) ? StParity : StStop;
                        bcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (at_vote) perr_d = vote ^ (^shift_q);
                if (at_wrap) state_d = StStop;
            end
            StStop: begin
                if (at_vote) begin
                    if (!valid_q || rx_ready) begin
                        data_d     = shift_q;
                        perr_out_d = (PARITY_EN != 0) && perr_q;
                        ferr_d     = !vote;
                        valid_d    = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                    // Leave mid-stop so a back-to-back start edge is not missed.
                    state_d = vote ? StIdle : StBreak;
                    scnt_d  = '0;
                end
            end
            StBreak: begin
                if (tick_16x && rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            scnt_q     <= '0;
            bcnt_q     <= '0;
            samp_q     <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            scnt_q     <= scnt_d;
            bcnt_q     <= bcnt_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_q     <= ferr_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_q;
    assign overrun    = overrun_q;
    assign rx_busy    = (state_q != StIdle);

endmodule
